tree_encoder_pipe: RTL

TREE_ENCODER_PIPE -- requirements
Module: tree_encoder_pipe

---
 rtl/tree_encoder_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tree_encoder_pipe.sv
// Pipelined decision-tree leaf encoder, one IEEE-754 compare per level.
// Define TREE_ENC_LEAF_COUNT_EN to add saturating per-leaf hit counters.
module tree_encoder_pipe #(
  parameter int DTYPE_SIZE = 32,
  parameter int EXP_SIZE   = 8,
  parameter int DEPTH      = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DTYPE_SIZE*DEPTH-1:0] x,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH-1:0]            x_enc,
  input  logic                        cfg_we,
  input  logic [DEPTH-1:0]            cfg_addr,
  input  logic [DTYPE_SIZE-1:0]       cfg_data,
  output logic                        cfg_err,
`ifdef TREE_ENC_LEAF_COUNT_EN
  input  logic                        cnt_clr,
  input  logic [DEPTH-1:0]            cnt_sel,
  output logic [15:0]                 cnt_value,
`endif
  output logic                        busy
);

  localparam int DW = DTYPE_SIZE;
  localparam int MW = DW - 1 - EXP_SIZE;
  localparam int XW = DW * DEPTH;
  localparam int TOTAL_SPLITS = (1 << DEPTH) - 1;

  // NaN never compares greater; +0 and -0 are equal.
  function automatic logic fp_gt(input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
    logic [DW-2:0] ma, mb;
    logic          a_nan, b_nan;
    ma    = a[DW-2:0];
    mb    = b[DW-2:0];
    a_nan = (&a[DW-2 -: EXP_SIZE]) && (|a[MW-1:0]);
    b_nan = (&b[DW-2 -: EXP_SIZE]) && (|b[MW-1:0]);
    if (a_nan || b_nan || (ma == '0 && mb == '0)) return 1'b0;
    if (a[DW-1] != b[DW-1]) return b[DW-1];
    if (a[DW-1]) return ma < mb;
    return ma > mb;
  endfunction

  logic [DW-1:0]    thr_q [TOTAL_SPLITS];
  logic [DW-1:0]    thr_d [TOTAL_SPLITS];
  logic             cfg_err_q, cfg_err_d;
  logic             wr_ok;
  logic [DEPTH-1:0] vld, adv;
  logic [DEPTH-1:0] code_w [DEPTH];
  logic [XW-1:0]    x_w [DEPTH];

  assign busy      = |vld;
  assign in_ready  = adv[0];
  assign out_valid = vld[DEPTH-1];
  assign x_enc     = code_w[DEPTH-1];
  assign cfg_err   = cfg_err_q;

  assign wr_ok = cfg_we && !busy && !in_valid &&
                 (int'(cfg_addr) < TOTAL_SPLITS);

  always_comb begin
    thr_d     = thr_q;
    cfg_err_d = cfg_we && !wr_ok;
    for (int n = 0; n < TOTAL_SPLITS; n++)
      if (wr_ok && cfg_addr == DEPTH'(n)) thr_d[n] = cfg_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err_q <= 1'b0;
      for (int n = 0; n < TOTAL_SPLITS; n++) thr_q[n] <= '0;
    end else begin
      cfg_err_q <= cfg_err_d;
      thr_q     <= thr_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic             v_in, v_d, v_q, gt;
    logic [DEPTH-1:0] c_in, c_d, c_q;
    logic [DW-1:0]    feat, thr;

    if (i == 0) begin : g_head
      assign v_in = in_valid;
      assign c_in = '0;
      assign feat = x[XW-1 -: DW];
    end else begin : g_body
      assign v_in = vld[i-1];
      assign c_in = code_w[i-1];
      assign feat = x_w[i-1][DW*(DEPTH-i)-1 -: DW];
    end

    // A stage can load if it or anything downstream has a free slot.
    assign adv[i]    = out_ready || !(&vld[DEPTH-1:i]);
    assign vld[i]    = v_q;
    assign code_w[i] = c_q;

    always_comb begin
      thr = '0;
      for (int n = 0; n < TOTAL_SPLITS; n++)
        if (n == (1 << i) - 1 + int'(c_in)) thr = thr_q[n];
    end

    assign gt = fp_gt(feat, thr);

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      if (adv[i]) begin
        v_d = v_in;
        c_d = (c_in << 1) | DEPTH'(gt);
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
      end
    end

    if (i < DEPTH - 1) begin : g_fwd
      logic [XW-1:0] x_src, x_d, x_q;
      if (i == 0) begin : g_src0
        assign x_src = x;
      end else begin : g_srcn
        assign x_src = x_w[i-1];
      end
      always_comb begin
        x_d = x_q;
        if (adv[i]) x_d = x_src;
      end
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) x_q <= '0;
        else          x_q <= x_d;
      end
      assign x_w[i] = x_q;
    end else begin : g_last
      assign x_w[i] = '0;
    end
  end

`ifdef TREE_ENC_LEAF_COUNT_EN
  localparam int LEAVES = 1 << DEPTH;

  logic [15:0] cnt_q [LEAVES];
  logic [15:0] cnt_d [LEAVES];

  always_comb begin
    for (int l = 0; l < LEAVES; l++) begin
      cnt_d[l] = cnt_q[l];
      if (cnt_clr)
        cnt_d[l] = '0;
      else if (out_valid && out_ready && x_enc == DEPTH'(l) &&
               cnt_q[l] != 16'hFFFF)
        cnt_d[l] = cnt_q[l] + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      for (int l = 0; l < LEAVES; l++) cnt_q[l] <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_value = cnt_q[cnt_sel];
`endif

endmodule
